// File: rtl/upg_pkg.sv
// Shared types and constants for the UART program loader: frame FSM states,
// byte receiver states and UPG port widths.
package upg_pkg;

   localparam int         UPG_ADDR_W    = 14;
   localparam int         UPG_DATA_W    = 32;
   localparam int         UPG_MAX_WORDS = 16384;
   localparam logic [7:0] UPG_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      SYNC,
      CNT_LO,
      CNT_HI,
      DATA,
      WRITE,
      DONE,
      ERROR
   } upg_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_BITS,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling timer and
// LSB-first shift register. Emits one-cycle byte_valid or frame_err pulses.
module uart_rx_byte
   import upg_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam logic [9:0] HALF_CNT = 10'(CLKS_PER_BIT / 2 - 1);
   localparam logic [9:0] FULL_CNT = 10'(CLKS_PER_BIT - 1);

   logic       rx_meta, rx_sync, rx_prev;
   rx_state_t  state, state_n;
   logic [9:0] cnt, cnt_n;
   logic [2:0] bit_idx, bit_idx_n;
   logic [7:0] shift, shift_n;
   logic       valid_n, ferr_n;

   // Line idles high, so the synchroniser resets to 1 to avoid a false start edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RX_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_idx    <= bit_idx_n;
         shift      <= shift_n;
         byte_valid <= valid_n;
         frame_err  <= ferr_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      valid_n   = 1'b0;
      ferr_n    = 1'b0;
      case (state)
         RX_IDLE: begin
            if (rx_prev && !rx_sync) begin
               state_n = RX_START;
               cnt_n   = '0;
            end
         end
         RX_START: begin
            if (cnt == HALF_CNT) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               // Line back high at the start-bit mid-point: a glitch, not a byte
               state_n   = rx_sync ? RX_IDLE : RX_BITS;
            end else begin
               cnt_n = cnt + 10'd1;
            end
         end
         RX_BITS: begin
            if (cnt == FULL_CNT) begin
               cnt_n     = '0;
               shift_n   = {rx_sync, shift[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = RX_STOP;
            end else begin
               cnt_n = cnt + 10'd1;
            end
         end
         RX_STOP: begin
            if (cnt == FULL_CNT) begin
               cnt_n   = '0;
               state_n = RX_IDLE;
               valid_n = rx_sync;
               ferr_n  = !rx_sync;
            end else begin
               cnt_n = cnt + 10'd1;
            end
         end
         default: state_n = RX_IDLE;
      endcase
   end

   assign rx_byte = shift;

endmodule

// File: rtl/uart_program_loader.sv
// UART bootloader front end: parses SYNC/count/data frames from the serial
// byte stream and issues one UPG write strobe per little-endian 32-bit word.
module uart_program_loader
   import upg_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 87,
   parameter int         MAX_WORDS    = UPG_MAX_WORDS,
   parameter logic [7:0] SYNC_BYTE    = UPG_SYNC_BYTE
) (
   input  logic                  iUpgClock,
   input  logic                  iUpgReset,
   input  logic                  iRx,
   output logic                  oUpgWriteEnable,
   output logic [UPG_ADDR_W-1:0] oUpgWriteAddress,
   output logic [UPG_DATA_W-1:0] oUpgWriteData,
   output logic                  oUpgDone,
   output logic                  oUpgError
);

   localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);

   logic                  byte_valid, frame_err;
   logic [7:0]            rx_byte;
   upg_state_t            state, state_n;
   logic [7:0]            count_lo;
   logic [15:0]           word_count;
   logic [15:0]           count_cand;
   logic                  bad_count, last_word;
   logic [UPG_ADDR_W-1:0] addr;
   logic [1:0]            byte_idx;
   logic [23:0]           word_buf;
   logic [UPG_ADDR_W-1:0] wr_addr;
   logic [UPG_DATA_W-1:0] wr_data;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk       (iUpgClock),
      .rst       (iUpgReset),
      .rx        (iRx),
      .byte_valid(byte_valid),
      .rx_byte   (rx_byte),
      .frame_err (frame_err)
   );

   assign count_cand = {rx_byte, count_lo};
   assign bad_count  = (count_cand == 16'd0) || ({1'b0, count_cand} > MAX_WORDS_W);
   assign last_word  = (({2'b00, addr} + 16'd1) == word_count);

   always_ff @(posedge iUpgClock or posedge iUpgReset) begin
      if (iUpgReset) state <= SYNC;
      else           state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (frame_err && state != DONE) begin
         state_n = ERROR;
      end else begin
         case (state)
            SYNC:    if (byte_valid && rx_byte == SYNC_BYTE) state_n = CNT_LO;
            CNT_LO:  if (byte_valid) state_n = CNT_HI;
            CNT_HI:  if (byte_valid) state_n = bad_count ? ERROR : DATA;
            DATA:    if (byte_valid && byte_idx == 2'd3) state_n = WRITE;
            WRITE:   state_n = last_word ? DONE : DATA;
            DONE:    state_n = DONE;
            ERROR:   state_n = ERROR;
            default: state_n = ERROR;
         endcase
      end
   end

   // The write port registers load as the 4th byte lands, so they are valid
   // during WRITE and then hold until the next word completes.
   always_ff @(posedge iUpgClock or posedge iUpgReset) begin
      if (iUpgReset) begin
         count_lo   <= '0;
         word_count <= '0;
         addr       <= '0;
         byte_idx   <= '0;
         word_buf   <= '0;
         wr_addr    <= '0;
         wr_data    <= '0;
      end else begin
         case (state)
            CNT_LO: if (byte_valid) count_lo <= rx_byte;
            CNT_HI: begin
               if (byte_valid) begin
                  word_count <= count_cand;
                  addr       <= '0;
                  byte_idx   <= '0;
               end
            end
            DATA: begin
               if (byte_valid && !frame_err) begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: word_buf[7:0]   <= rx_byte;
                     2'd1: word_buf[15:8]  <= rx_byte;
                     2'd2: word_buf[23:16] <= rx_byte;
                     default: begin
                        wr_addr <= addr;
                        wr_data <= {rx_byte, word_buf};
                     end
                  endcase
               end
            end
            WRITE: addr <= addr + 14'd1;
            default: ;
         endcase
      end
   end

   assign oUpgWriteEnable  = (state == WRITE);
   assign oUpgWriteAddress = wr_addr;
   assign oUpgWriteData    = wr_data;
   assign oUpgDone         = (state == DONE);
   assign oUpgError        = (state == ERROR);

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: fixed frame vectors, hand-built corner
// sequences and random frames checked against a frame-level reference model.
module tb_uart_program_loader;

   localparam int CPB = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic        we;
   logic [13:0] waddr;
   logic [31:0] wdata;
   logic        done;
   logic        err;

   uart_program_loader #(.CLKS_PER_BIT(CPB)) dut (
      .iUpgClock       (clk),
      .iUpgReset       (rst),
      .iRx             (rx),
      .oUpgWriteEnable (we),
      .oUpgWriteAddress(waddr),
      .oUpgWriteData   (wdata),
      .oUpgDone        (done),
      .oUpgError       (err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Strobe log and event timing, written only by the monitor
   logic [13:0] st_addr[$];
   logic [31:0] st_data[$];
   int          cyc = 0;
   int          last_str_cyc = 0;
   int          done_rise_cyc = 0;
   int          last_bv_cyc = 0;
   int          last_lat = 0;
   int          n_bytes = 0;
   logic        done_q = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (we) begin
         st_addr.push_back(waddr);
         st_data.push_back(wdata);
         last_str_cyc = cyc;
         last_lat     = cyc - last_bv_cyc;
      end
      if (done && !done_q) done_rise_cyc = cyc;
      done_q = done;
      if (dut.u_rx.byte_valid) begin
         n_bytes     = n_bytes + 1;
         last_bv_cyc = cyc;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         rx = b[k];
         repeat (CPB) @(negedge clk);
      end
      rx = bad_stop ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   logic [7:0] tx_bytes[$];
   bit         tx_bad[$];

   task automatic send_queue();
      for (int i = 0; i < tx_bytes.size(); i++) send_byte(tx_bytes[i], tx_bad[i]);
      repeat (20) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] b);
      tx_bytes.push_back(b);
      tx_bad.push_back(1'b0);
   endtask

   // Reference model: locate the first sync byte, read the count, then cut
   // the following bytes into 4-byte words; any bad stop bit before the image
   // completes is fatal.
   logic [31:0] exp_data[$];
   logic        exp_done, exp_err;

   task automatic run_model();
      int          n, p, words, idx;
      logic [31:0] word;
      exp_data.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      n = tx_bytes.size();
      p = -1;
      for (int i = 0; i < n; i++) begin
         if (tx_bad[i]) begin
            exp_err = 1'b1;
            return;
         end
         if (tx_bytes[i] == 8'hA5) begin
            p = i;
            break;
         end
      end
      if (p < 0) return;
      for (int i = p + 1; i <= p + 2 && i < n; i++) begin
         if (tx_bad[i]) begin
            exp_err = 1'b1;
            return;
         end
      end
      if (p + 2 >= n) return;
      words = int'(tx_bytes[p+2]) * 256 + int'(tx_bytes[p+1]);
      if (words == 0 || words > 16384) begin
         exp_err = 1'b1;
         return;
      end
      for (int w = 0; w < words; w++) begin
         word = '0;
         for (int k = 0; k < 4; k++) begin
            idx = p + 3 + 4 * w + k;
            if (idx >= n) return;
            if (tx_bad[idx]) begin
               exp_err = 1'b1;
               return;
            end
            word[8*k +: 8] = tx_bytes[idx];
         end
         exp_data.push_back(word);
      end
      exp_done = 1'b1;
   endtask

   typedef struct {
      logic [127:0] b;
      int           len;
      int           bad;
      int           n_str;
      logic [31:0]  d0;
      logic [31:0]  d1;
      logic         done;
      logic         err;
   } vec_t;

   localparam int NV = 6;
   vec_t vec[NV];

   int base;
   int nb;

   initial begin
      vec[0] = '{b: {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE},
                 len: 11, bad: -1, n_str: 2, d0: 32'h12345678, d1: 32'hDEADBEEF, done: 1'b1, err: 1'b0};
      vec[1] = '{b: {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00},
                 len: 10, bad: -1, n_str: 1, d0: 32'h00000001, d1: 32'h0, done: 1'b1, err: 1'b0};
      vec[2] = '{b: {8'hA5, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44},
                 len: 7, bad: -1, n_str: 0, d0: 32'h0, d1: 32'h0, done: 1'b0, err: 1'b1};
      vec[3] = '{b: {8'hA5, 8'h01, 8'h40, 8'h11, 8'h22, 8'h33, 8'h44},
                 len: 7, bad: -1, n_str: 0, d0: 32'h0, d1: 32'h0, done: 1'b0, err: 1'b1};
      vec[4] = '{b: {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66},
                 len: 9, bad: 5, n_str: 0, d0: 32'h0, d1: 32'h0, done: 1'b0, err: 1'b1};
      vec[5] = '{b: {8'h33, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44},
                 len: 8, bad: 0, n_str: 0, d0: 32'h0, d1: 32'h0, done: 1'b0, err: 1'b1};

      // Reset state, sampled while reset is held
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      check("reset we", 64'(we), 64'd0);
      check("reset addr", 64'(waddr), 64'd0);
      check("reset data", 64'(wdata), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset err", 64'(err), 64'd0);

      for (int v = 0; v < NV; v++) begin
         do_reset();
         tx_bytes.delete();
         tx_bad.delete();
         for (int i = 0; i < vec[v].len; i++) begin
            tx_bytes.push_back(vec[v].b[8*(vec[v].len-1-i) +: 8]);
            tx_bad.push_back(i == vec[v].bad);
         end
         base = st_addr.size();
         send_queue();
         check($sformatf("v%0d strobes", v), 64'(st_addr.size() - base), 64'(vec[v].n_str));
         for (int s = 0; s < vec[v].n_str && base + s < st_addr.size(); s++) begin
            check($sformatf("v%0d addr%0d", v, s), 64'(st_addr[base+s]), 64'(s));
            check($sformatf("v%0d data%0d", v, s), 64'(st_data[base+s]), 64'(s == 0 ? vec[v].d0 : vec[v].d1));
         end
         check($sformatf("v%0d done", v), 64'(done), 64'(vec[v].done));
         check($sformatf("v%0d err", v), 64'(err), 64'(vec[v].err));
         if (vec[v].done) begin
            check($sformatf("v%0d done delay", v), 64'(done_rise_cyc - last_str_cyc), 64'd1);
            check($sformatf("v%0d strobe latency", v), 64'(last_lat), 64'd1);
            check($sformatf("v%0d held addr", v), 64'(waddr), 64'(vec[v].n_str - 1));
            check($sformatf("v%0d held data", v), 64'(wdata), 64'(vec[v].n_str == 1 ? vec[v].d0 : vec[v].d1));
         end
      end

      // Reset mid-frame after two data bytes, then a clean one-word frame
      do_reset();
      base = st_addr.size();
      tx_bytes.delete();
      tx_bad.delete();
      push(8'hA5); push(8'h01); push(8'h00); push(8'hAA); push(8'hBB);
      send_queue();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst done", 64'(done), 64'd0);
      check("midrst err", 64'(err), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst no strobe", 64'(st_addr.size() - base), 64'd0);
      tx_bytes.delete();
      tx_bad.delete();
      push(8'hA5); push(8'h01); push(8'h00); push(8'h0D); push(8'hF0); push(8'hFE); push(8'hCA);
      send_queue();
      check("midrst strobes", 64'(st_addr.size() - base), 64'd1);
      if (st_addr.size() > base) begin
         check("midrst addr", 64'(st_addr[base]), 64'd0);
         check("midrst data", 64'(st_data[base]), 64'h0000_0000_CAFE_F00D);
      end
      check("midrst done after", 64'(done), 64'd1);

      // A further frame after done is ignored
      base = st_addr.size();
      tx_bytes.delete();
      tx_bad.delete();
      push(8'hA5); push(8'h01); push(8'h00); push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      send_queue();
      check("postdone strobes", 64'(st_addr.size() - base), 64'd0);
      check("postdone done", 64'(done), 64'd1);
      check("postdone err", 64'(err), 64'd0);

      // Two-cycle low glitch on the line
      do_reset();
      base = st_addr.size();
      nb   = n_bytes;
      rx   = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (10 * CPB) @(negedge clk);
      check("glitch bytes", 64'(n_bytes - nb), 64'd0);
      check("glitch err", 64'(err), 64'd0);
      check("glitch strobes", 64'(st_addr.size() - base), 64'd0);

      // Random frames: garbage prefix, 1..3 words, optional bad stop, trailing bytes
      for (int r = 0; r < 8; r++) begin
         int          g, nw, nd, first_data;
         logic [7:0]  rb;
         do_reset();
         tx_bytes.delete();
         tx_bad.delete();
         g = $urandom_range(0, 3);
         for (int i = 0; i < g; i++) begin
            rb = 8'($urandom_range(0, 255));
            if (rb == 8'hA5) rb = 8'h3C;
            push(rb);
         end
         nw = $urandom_range(1, 3);
         push(8'hA5); push(8'(nw)); push(8'h00);
         first_data = tx_bytes.size();
         nd = 4 * nw;
         for (int i = 0; i < nd; i++) push(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 2) == 0) tx_bad[first_data + $urandom_range(0, nd - 1)] = 1'b1;
         for (int i = 0; i < int'($urandom_range(0, 2)); i++) push(8'($urandom_range(0, 255)));
         run_model();
         base = st_addr.size();
         send_queue();
         check($sformatf("rnd%0d strobes", r), 64'(st_addr.size() - base), 64'(exp_data.size()));
         for (int s = 0; s < exp_data.size() && base + s < st_addr.size(); s++) begin
            check($sformatf("rnd%0d addr%0d", r, s), 64'(st_addr[base+s]), 64'(s));
            check($sformatf("rnd%0d data%0d", r, s), 64'(st_data[base+s]), 64'(exp_data[s]));
         end
         check($sformatf("rnd%0d done", r), 64'(done), 64'(exp_done));
         check($sformatf("rnd%0d err", r), 64'(err), 64'(exp_err));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- UART bootloader front end that produces the UPG write stream consumed by the program ROM's programming port.
- Receives 8N1 serial bytes on one pin and parses a framed program image.
- Assembles little-endian 32-bit words and issues one single-cycle write per word, with sequential word addresses from 0.
- Raises a sticky done flag when the image is complete, which hands the ROM back to the CPU.
- Runs entirely in the UPG clock domain (10 MHz on board).

Parameters:
- CLKS_PER_BIT, 87, UPG clock cycles per UART bit (10 MHz / 115200 baud); legal range 4..1023.
- MAX_WORDS, 16384, highest legal word count (equals the 14-bit ROM depth).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- iUpgClock  input  1  UPG clock; every flop is rising-edge on this clock.
- iUpgReset  input  1  asynchronous, active-high reset.
- iRx  input  1  UART serial in; idles high; asynchronous to iUpgClock.
- oUpgWriteEnable  output  1  one-cycle write strobe to the ROM programming port.
- oUpgWriteAddress  output  14  word address, valid while oUpgWriteEnable is high.
- oUpgWriteData  output  32  word data, valid while oUpgWriteEnable is high.
- oUpgDone  output  1  sticky; 1 after the last word has been written.
- oUpgError  output  1  sticky; 1 after a framing or length error.

Behaviour:
- Reset values: all outputs 0, FSM in SYNC, byte receiver idle. Reset asserted mid-frame aborts the load immediately; no further strobes occur until a new frame arrives.
- iRx synchronisation: 2-flop synchroniser before any use.
- Start-bit detection: falling edge of synchronised iRx while the receiver is idle.
- Start-bit check: resample at CLKS_PER_BIT/2. If the line is high, treat it as a glitch and return to idle with no byte.
- Data bits: sample 8 bits, LSB first, each CLKS_PER_BIT apart, measured from the start-bit mid-point.
- Stop bit: sample at the stop-bit mid-point.
  - Stop = 1: pulse byte_valid for one cycle with the byte.
  - Stop = 0: pulse frame_err for one cycle; no byte_valid.
- Frame format: SYNC_BYTE, count_lo, count_hi, then 4*N data bytes. N = {count_hi, count_lo}. Each word is sent little-endian (byte 0 = bits 7:0).
- SYNC state: bytes other than SYNC_BYTE are discarded. SYNC_BYTE moves to CNT_LO.
- CNT_LO: latch the low count byte, go to CNT_HI.
- CNT_HI: latch the high count byte.
  - N == 0 or N > MAX_WORDS: go to ERROR.
  - Otherwise: clear the address counter and byte index, go to DATA.
- DATA: each byte shifts into the word buffer at lane byte_idx; byte_idx wraps 3 to 0. When the 4th byte is accepted, go to WRITE.
- WRITE (exactly 1 cycle):
  - oUpgWriteEnable = 1; oUpgWriteAddress = current address; oUpgWriteData = assembled word.
  - Next cycle: strobe returns to 0 and address increments.
  - If that was word N, go to DONE; otherwise return to DATA.
- Write latency: the strobe occurs 1 cycle after byte_valid of the word's 4th byte.
- Address width: the 14-bit address counter never wraps within a legal frame (N ≤ 16384). Address 16383 is the final legal write.
- DONE: oUpgDone = 1; all further bytes ignored; no strobes. Leave only by iUpgReset.
- ERROR: oUpgError = 1, oUpgDone stays 0, no strobes. Leave only by iUpgReset.
- frame_err in any state other than DONE: go to ERROR. In SYNC this counts too; a line break is a fault.
- Outputs between strobes: oUpgWriteAddress and oUpgWriteData hold their last value while oUpgWriteEnable = 0.
- Byte timing: byte_valid and the WRITE cycle cannot coincide, because bytes are at least 10*CLKS_PER_BIT cycles apart.

Decomposition:
- Shared package upg_pkg:
  - FSM state enum: SYNC, CNT_LO, CNT_HI, DATA, WRITE, DONE, ERROR.
  - UPG_ADDR_W = 14, UPG_DATA_W = 32, default SYNC_BYTE.
- One sub-module uart_rx_byte:
  - Contains the synchroniser, bit timer and shift register.
  - Outputs: byte_valid, byte[7:0], frame_err.
  - Parameterised by CLKS_PER_BIT.
- Top level holds the frame FSM, count, address and word buffer.

Test Plan:
- Basic load, CLKS_PER_BIT = 8: send A5 02 00 78 56 34 12 EF BE AD DE.
  - Required: exactly two strobes, addr 0 data 32'h12345678, then addr 1 data 32'hDEADBEEF.
  - Required: oUpgDone = 1 one cycle after the 2nd strobe.
- Leading garbage: send 00 FF 5A, then A5 01 00 01 00 00 00.
  - Required: a single strobe, addr 0 data 32'h00000001; done = 1.
- Length errors: count bytes 00 00, and separately 01 40 (N = 16385).
  - Required in both cases: oUpgError = 1, no strobe, done = 0.
- Framing error: corrupt the stop bit to 0 on the 3rd data byte.
  - Required: error = 1, no strobe for word 0, subsequent bytes ignored.
- Reset mid-frame: assert iUpgReset after 2 data bytes, release it, then send a full 1-word frame with data 32'hCAFEF00D.
  - Required: one strobe at addr 0 with 32'hCAFEF00D; done = 1.
- Post-done and glitch handling:
  - After done, send A5 01 00 and 4 more bytes. Required: no further strobes; done stays 1.
  - Send a 2-cycle low glitch on iRx. Required: no byte, no error.
